// File: rtl/mem_arbiter.sv
// Two-master memory arbiter: an icache fetch port and a read/write data port share one
// synchronous single-port memory, with round-robin tie-break, burst timeout and a data-port grant cap.
module mem_arbiter #(
  parameter int BURST_MAX = 20,
  parameter int DP_MAX    = 4,
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clk_en,
  input  logic              ic_mreq,
  input  logic [ADDR_W-1:0] ic_addr,
  output logic              ic_gnt,
  output logic              ic_stall,
  output logic [DATA_W-1:0] ic_rdata,
  input  logic              dp_req,
  input  logic              dp_we,
  input  logic [ADDR_W-1:0] dp_addr,
  input  logic [DATA_W-1:0] dp_wdata,
  output logic              dp_gnt,
  output logic              dp_rvalid,
  output logic [DATA_W-1:0] dp_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              err_timeout
);

  localparam int BW = $clog2(BURST_MAX + 1);
  localparam int DW = $clog2(DP_MAX + 1);

  typedef enum logic [1:0] {IDLE, IC, DP} state_t;

  state_t          state, state_nxt;
  state_t          last_owner, last_owner_nxt;
  logic [BW-1:0]   burst_cnt, burst_cnt_nxt;
  logic [DW-1:0]   dp_cnt, dp_cnt_nxt;
  logic            err_nxt;
  logic            rvld_p1;
  logic            dp_access;

  function automatic logic [DW-1:0] dp_sat_inc(input logic [DW-1:0] c);
    return (c >= DW'(DP_MAX)) ? DW'(DP_MAX) : c + DW'(1);
  endfunction

  always_comb begin
    state_nxt      = state;
    last_owner_nxt = last_owner;
    burst_cnt_nxt  = burst_cnt;
    dp_cnt_nxt     = dp_cnt;
    err_nxt        = err_timeout;
    case (state)
      IDLE: begin
        if (ic_mreq && (!dp_req || last_owner == DP)) state_nxt = IC;
        else if (dp_req)                              state_nxt = DP;
      end
      IC: begin
        if (!ic_mreq || burst_cnt == BW'(BURST_MAX - 1)) begin
          // Forced release when the icache has held memory too long
          err_nxt        = err_timeout | ic_mreq;
          state_nxt      = IDLE;
          last_owner_nxt = IC;
          burst_cnt_nxt  = '0;
        end else begin
          burst_cnt_nxt = burst_cnt + BW'(1);
        end
      end
      DP: begin
        if (!dp_req) begin
          state_nxt      = IDLE;
          last_owner_nxt = DP;
          dp_cnt_nxt     = '0;
        end else begin
          dp_cnt_nxt = dp_sat_inc(dp_cnt);
          if (ic_mreq && dp_cnt_nxt == DW'(DP_MAX)) begin
            state_nxt      = IDLE;
            last_owner_nxt = DP;
            dp_cnt_nxt     = '0;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      last_owner  <= DP;
      burst_cnt   <= '0;
      dp_cnt      <= '0;
      err_timeout <= 1'b0;
    end else if (clk_en) begin
      state       <= state_nxt;
      last_owner  <= last_owner_nxt;
      burst_cnt   <= burst_cnt_nxt;
      dp_cnt      <= dp_cnt_nxt;
      err_timeout <= err_nxt;
    end
  end

  // Stage p0 -> p1: memory returns read data one cycle after the granted address
  always_ff @(posedge clk) begin
    if (rst)         rvld_p1 <= 1'b0;
    else if (clk_en) rvld_p1 <= dp_gnt && !dp_we;
  end

  assign dp_access = (state == DP) && dp_req;
  // Grant and write are suppressed on a reset cycle so an aborted transfer never writes
  assign ic_gnt    = (state == IC);
  assign dp_gnt    = dp_access && clk_en && !rst;
  assign ic_stall  = ic_mreq && !ic_gnt;
  assign ic_rdata  = mem_rdata;
  assign mem_addr  = dp_access ? dp_addr : ic_addr;
  assign mem_we    = dp_gnt && dp_we;
  assign mem_wdata = dp_access ? dp_wdata : '0;
  assign dp_rvalid = rvld_p1;
  assign dp_rdata  = rvld_p1 ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural 1-cycle-latency memory.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst, clk_en, ic_mreq, dp_req, dp_we;
  logic [9:0]  ic_addr, dp_addr, mem_addr;
  logic [15:0] dp_wdata, ic_rdata, dp_rdata, mem_wdata, mem_rdata;
  logic        ic_gnt, ic_stall, dp_gnt, dp_rvalid, mem_we, err_timeout;

  int n_chk = 0;
  int n_bad = 0;
  int gcnt;

  logic [15:0] mem [0:1023];
  bit          written [0:1023];

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk(clk), .rst(rst), .clk_en(clk_en),
    .ic_mreq(ic_mreq), .ic_addr(ic_addr), .ic_gnt(ic_gnt), .ic_stall(ic_stall), .ic_rdata(ic_rdata),
    .dp_req(dp_req), .dp_we(dp_we), .dp_addr(dp_addr), .dp_wdata(dp_wdata),
    .dp_gnt(dp_gnt), .dp_rvalid(dp_rvalid), .dp_rdata(dp_rdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .err_timeout(err_timeout)
  );

  // Unwritten locations read back as 0xA5A5 ^ address
  always @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr]     <= mem_wdata;
      written[mem_addr] <= 1'b1;
    end
    mem_rdata <= written[mem_addr] ? mem[mem_addr] : (16'hA5A5 ^ {6'd0, mem_addr});
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) chk("excl", 32'(ic_gnt & dp_gnt), 0);

  initial begin
    rst = 1; clk_en = 1; ic_mreq = 0; ic_addr = '0;
    dp_req = 0; dp_we = 0; dp_addr = '0; dp_wdata = '0;
    tick(); tick();
    chk("rst_ic_gnt", 32'(ic_gnt), 0);
    chk("rst_dp_gnt", 32'(dp_gnt), 0);
    chk("rst_mem_we", 32'(mem_we), 0);
    chk("rst_wdata", 32'(mem_wdata), 0);
    chk("rst_rdata", 32'(dp_rdata), 0);
    chk("rst_rvalid", 32'(dp_rvalid), 0);
    chk("rst_err", 32'(err_timeout), 0);

    // Simultaneous request after reset, then alternate
    rst = 0; ic_mreq = 1; dp_req = 1; dp_addr = 10'h005; ic_addr = 10'h020; #1;
    chk("tie_stall", 32'(ic_stall), 1);
    tick(); ic_mreq = 0; #1;
    chk("tie_ic_win", 32'(ic_gnt), 1);
    chk("tie_dp_lose", 32'(dp_gnt), 0);
    chk("tie_maddr", 32'(mem_addr), 32'h020);
    tick(); #1;
    chk("alt_idle_dp", 32'(dp_gnt), 0);
    chk("alt_idle_ic", 32'(ic_gnt), 0);
    tick(); #1;
    chk("alt_dp_gnt", 32'(dp_gnt), 1);
    chk("alt_maddr", 32'(mem_addr), 32'h005);
    tick(); #1;
    chk("alt_rvalid", 32'(dp_rvalid), 1);
    chk("alt_rdata", 32'(dp_rdata), 32'hA5A0);
    dp_req = 0; #1;
    chk("drop_no_gnt", 32'(dp_gnt), 0);
    tick(); ic_mreq = 1; dp_req = 1; #1;
    chk("drop_rvalid", 32'(dp_rvalid), 0);
    tick(); #1;
    chk("tie2_ic", 32'(ic_gnt), 1);
    chk("tie2_dp", 32'(dp_gnt), 0);
    ic_mreq = 0; dp_req = 0;
    tick(); #1;

    // 17-cycle icache burst
    ic_mreq = 1; ic_addr = 10'h100; #1;
    chk("bst_pre_gnt", 32'(ic_gnt), 0);
    chk("bst_pre_stall", 32'(ic_stall), 1);
    for (int i = 1; i <= 17; i++) begin
      tick();
      ic_addr = 10'(32'h100 + i);
      if (i == 17) ic_mreq = 0;
      #1;
      chk("bst_gnt", 32'(ic_gnt), 1);
      chk("bst_addr", 32'(mem_addr), 32'h100 + i);
    end
    tick(); #1;
    chk("bst_end", 32'(ic_gnt), 0);
    chk("bst_err", 32'(err_timeout), 0);

    // Data-port cap: write 0x3FF then reads, icache waiting
    dp_req = 1; dp_we = 1; dp_addr = 10'h3FF; dp_wdata = 16'hBEEF;
    tick();
    gcnt = 0;
    for (int c = 0; c <= 5; c++) begin
      if (c > 0) tick();
      if (c == 0) ic_mreq = 1;
      if (c == 1) dp_we = 0;
      #1;
      if (dp_gnt) gcnt++;
      if (c == 0) begin
        chk("cap_we", 32'(mem_we), 1);
        chk("cap_addr", 32'(mem_addr), 32'h3FF);
        chk("cap_wdata", 32'(mem_wdata), 32'hBEEF);
        chk("cap_stall", 32'(ic_stall), 1);
      end
      if (c == 1) chk("cap_wr_novld", 32'(dp_rvalid), 0);
      if (c == 2) begin
        chk("cap_rvalid", 32'(dp_rvalid), 1);
        chk("cap_rdata", 32'(dp_rdata), 32'hBEEF);
      end
      if (c == 4) chk("cap_idle", 32'(ic_gnt | dp_gnt), 0);
      if (c == 5) chk("cap_ic", 32'(ic_gnt), 1);
    end
    chk("cap_gnts", 32'(gcnt), 4);
    ic_mreq = 0; dp_req = 0;
    tick();

    // Clock enable low mid-DP
    dp_req = 1; dp_we = 0; dp_addr = 10'h3FF;
    tick(); #1;
    chk("ce_gnt0", 32'(dp_gnt), 1);
    tick();
    clk_en = 0; dp_we = 1; dp_addr = 10'h020; dp_wdata = 16'h1234; ic_mreq = 1; #1;
    for (int k = 0; k < 3; k++) begin
      chk("ce_we", 32'(mem_we), 0);
      chk("ce_gnt", 32'(dp_gnt), 0);
      chk("ce_rvalid", 32'(dp_rvalid), 1);
      chk("ce_ic", 32'(ic_gnt), 0);
      tick();
    end
    clk_en = 1; #1;
    gcnt = 0;
    for (int c = 0; c <= 4; c++) begin
      if (c > 0) tick();
      if (dp_gnt) gcnt++;
      if (c == 0) chk("ce_resume_we", 32'(mem_we), 1);
      if (c == 4) chk("ce_ic", 32'(ic_gnt), 1);
    end
    chk("ce_gnts", 32'(gcnt), 3);
    ic_mreq = 0; dp_req = 0;
    tick();

    // Stuck icache request -> timeout
    ic_mreq = 1;
    gcnt = 0;
    for (int c = 1; c <= 21; c++) begin
      tick();
      if (ic_gnt) gcnt++;
      if (c == 20) chk("to_err_early", 32'(err_timeout), 0);
      if (c == 21) begin
        chk("to_release", 32'(ic_gnt), 0);
        chk("to_err", 32'(err_timeout), 1);
      end
    end
    chk("to_cycles", 32'(gcnt), 20);
    ic_mreq = 0;
    tick(); tick(); tick();
    chk("to_sticky", 32'(err_timeout), 1);

    // Reset in the middle of a write burst
    dp_req = 1; dp_we = 1; dp_addr = 10'h040; dp_wdata = 16'h5555;
    tick(); #1;
    chk("rw_we", 32'(mem_we), 1);
    tick();
    dp_addr = 10'h041; dp_wdata = 16'h7777; rst = 1; #1;
    chk("rw_rst_we", 32'(mem_we), 0);
    chk("rw_rst_gnt", 32'(dp_gnt), 0);
    tick(); #1;
    chk("rw_ic_gnt", 32'(ic_gnt), 0);
    chk("rw_dp_gnt", 32'(dp_gnt), 0);
    chk("rw_mem_we", 32'(mem_we), 0);
    chk("rw_wdata", 32'(mem_wdata), 0);
    chk("rw_rdata", 32'(dp_rdata), 0);
    chk("rw_rvalid", 32'(dp_rvalid), 0);
    chk("rw_err", 32'(err_timeout), 0);
    rst = 0; dp_we = 0; dp_addr = 10'h041;
    tick(); #1;
    chk("rw_rd_gnt", 32'(dp_gnt), 1);
    tick(); #1;
    chk("rw_rd_vld", 32'(dp_rvalid), 1);
    chk("rw_no_write", 32'(dp_rdata), 32'hA5E4);
    dp_addr = 10'h040;
    tick(); #1;
    chk("rw_prev_write", 32'(dp_rdata), 32'h5555);
    dp_req = 0;
    tick();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
